gray_codec_pipe: RTL and testbench

GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

---
 rtl/gray_codec_pkg.sv | 9 +
 rtl/gray_codec_pipe_xlate.sv | 28 ++
 rtl/gray_codec_pipe.sv | 93 +++++++++
 tb/tb_gray_codec_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_codec_pkg.sv
// Shared definitions for the gray code converter pipeline.
// Holds the per-word conversion mode encodings used by the datapath and converter.
package gray_codec_pkg;

    // Conversion mode carried alongside every word
    localparam logic MODE_B2G = 1'b0;   // binary -> gray
    localparam logic MODE_G2B = 1'b1;   // gray -> binary

endpackage : gray_codec_pkg

// File: rtl/gray_codec_pipe_xlate.sv
// gray_xlate: combinational binary<->gray converter.
// Ports:
//   d    - input word (WIDTH bits)
//   mode - MODE_B2G or MODE_G2B
//   q    - converted word (WIDTH bits)
module gray_xlate
    import gray_codec_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic             mode,
    output logic [WIDTH-1:0] q
);

    // B2G xors each bit with its upper neighbour; G2B bit i is the xor of all bits at or above i
    always_comb begin
        q = '0;
        if (mode == MODE_G2B) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                q[i] = ^(d >> i);
            end
        end else begin
            q = d ^ (d >> 1);
        end
    end

endmodule : gray_xlate

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: two-stage valid/ready pipeline converting words between
// binary and gray code, with a per-word mode and a completed-transfer counter.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake; in_data/in_mode are the word and its mode
//   out_valid/out_ready - output handshake; out_data/out_mode are the result and its mode
//   xfer_cnt            - wrapping count of completed output handshakes
//   out_parity          - xor-reduction of out_data, present only when
//                         GRAY_CODEC_PARITY_EN is defined
module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef GRAY_CODEC_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_mode;
    logic             s2_free;
    logic [WIDTH-1:0] xlate_q;

    // Stage 2 (the output register) can take a word when empty or draining this cycle
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    gray_xlate #(
        .WIDTH (WIDTH)
    ) u_xlate (
        .d    (s1_data),
        .mode (s1_mode),
        .q    (xlate_q)
    );

    // Pipeline registers and transfer counter; both stages may advance in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= MODE_B2G;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= MODE_B2G;
            xfer_cnt  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_ready && in_valid) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
            end
            if (s2_free) begin
                out_valid <= s1_valid;
            end
            if (s2_free && s1_valid) begin
                out_data <= xlate_q;
                out_mode <= s1_mode;
            end
            if (out_valid && out_ready) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

`ifdef GRAY_CODEC_PARITY_EN
    // Parity loads with out_data so it holds under stall exactly like the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else if (s2_free && s1_valid) begin
            out_parity <= ^xlate_q;
        end
    end
`endif

endmodule : gray_codec_pipe

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench for gray_codec_pipe (WIDTH=4, CNT_W=3): directed cases
// plus randomized traffic against a queue-based reference model.
module tb_gray_codec_pipe;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;

    typedef struct {
        logic [W-1:0] data;
        logic         mode;
        int           acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_mode;
    logic [CW-1:0] xfer_cnt;
`ifdef GRAY_CODEC_PARITY_EN
    logic          out_parity;
`endif

    int   errors = 0;
    int   checks = 0;
    int   ecnt = 0;
    int   exp_cnt = 0;
    exp_t q[$];

    gray_codec_pipe #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .xfer_cnt  (xfer_cnt)
`ifdef GRAY_CODEC_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray-to-binary as the inverse of the binary-to-gray map
    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] r;
        r = '0;
        for (int v = 0; v < (1 << W); v++) begin
            if (ref_b2g(W'(v)) == g) r = W'(v);
        end
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model, advance model with the edge
    task automatic tick(output bit acc);
        bit   exp_ir;
        bit   exp_ov;
        bit   out_fire;
        exp_t e;
        #1;
        exp_ir = (q.size() < 2) || out_ready;
        exp_ov = 1'b0;
        if (q.size() > 0) exp_ov = (ecnt >= q[0].acc + 1);
        check_val("in_ready", 32'(in_ready), 32'(exp_ir));
        check_val("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check_val("out_data", 32'(out_data), 32'(q[0].data));
            check_val("out_mode", 32'(out_mode), 32'(q[0].mode));
`ifdef GRAY_CODEC_PARITY_EN
            check_val("out_parity", 32'(out_parity), 32'($countones(q[0].data) % 2));
`endif
        end
        acc      = in_valid && exp_ir;
        out_fire = exp_ov && out_ready;
        e.data   = in_mode ? ref_g2b(in_data) : ref_b2g(in_data);
        e.mode   = in_mode;
        e.acc    = ecnt + 1;
        @(posedge clk);
        ecnt++;
        if (out_fire) begin
            void'(q.pop_front());
            exp_cnt++;
        end
        if (acc) q.push_back(e);
        #1;
        check_val("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt % (1 << CW)));
    endtask

    // Present one word until accepted (bounded)
    task automatic send(input logic [W-1:0] d, input logic m);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int n = 0; n < 20 && !done; n++) begin
            tick(acc);
            done = acc;
        end
        if (!done) check_val("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        in_data   = W'($urandom);
        out_ready = 1'b1;
        for (int n = 0; n < 10 && q.size() > 0; n++) tick(acc);
        tick(acc);
    endtask

    initial begin
        bit           acc;
        int           idx;
        logic [W-1:0] words [4];

        // Reset state
        #2;
        check_val("rst_out_valid", 32'(out_valid), 32'(0));
        check_val("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        check_val("rst_out_data", 32'(out_data), 32'(0));
        check_val("rst_out_mode", 32'(out_mode), 32'(0));
`ifdef GRAY_CODEC_PARITY_EN
        check_val("rst_out_parity", 32'(out_parity), 32'(0));
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // B2G directed
        out_ready = 1'b1;
        send(4'b0101, 1'b0);
        send(4'b1111, 1'b0);
        drain();

        // G2B back-to-back
        send(4'b0110, 1'b1);
        send(4'b1111, 1'b1);
        send(4'b1000, 1'b1);
        drain();

        // Mode alternating per word
        send(4'b0011, 1'b0);
        send(4'b0011, 1'b1);
        drain();

        // Backpressure: sink stalled 5 cycles while 4 words stream
        words[0] = 4'b0001; words[1] = 4'b1001; words[2] = 4'b0110; words[3] = 4'b1110;
        idx = 0;
        out_ready = 1'b0;
        for (int n = 0; n < 30 && idx < 4; n++) begin
            out_ready = (n >= 5);
            in_valid  = 1'b1;
            in_data   = words[idx];
            in_mode   = idx[0];
            tick(acc);
            if (acc) idx++;
        end
        if (idx != 4) check_val("bp_timeout", 32'(idx), 32'(4));
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(4'b1010, 1'b0);
        send(4'b0101, 1'b1);
        in_valid = 1'b0;
        tick(acc);
        rst = 1'b1;
        #1;
        check_val("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check_val("mid_rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        check_val("mid_rst_out_data", 32'(out_data), 32'(0));
        q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Nine transfers wrap the 3-bit counter to 1; includes a 1010 result
        send(4'b1100, 1'b0);
        for (int k = 0; k < 8; k++) send(W'($urandom), 1'($urandom));
        drain();
        check_val("wrap_xfer_cnt", 32'(xfer_cnt), 32'(1));

        // Randomized traffic with random backpressure and garbage on idle inputs
        for (int n = 0; n < 400; n++) begin
            in_valid  = 1'($urandom);
            in_data   = W'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gray_codec_pipe
